// File: rtl/tube_scan_driver.sv
// tube_scan_driver
// Self-timed four-digit seven-segment scan driver. It multiplexes the digits
// on its own prescaled timebase and inserts a blank interval at the start of
// every digit slot so the previous digit does not ghost into the next. The
// displayed value, dots and leading-zero mode are captured once per frame so
// a frame is never torn by a mid-scan input change. Pins are registered and
// computed from next-state values, so they always agree with the current
// (cnt, idx, shadow) state.

module tube_scan_driver #(
  parameter int PRESCALE       = 1000,
  parameter int BLANK          = 16,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dots,
  input  logic        blankLeading,
  output logic [3:0]  tubeDig,
  output logic [7:0]  tubeSeg,
  output logic        frameStart
);

  localparam int             CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);
  localparam bit             DIG_LOW  = (DIG_ACTIVE_LOW != 0);
  localparam bit             SEG_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic [3:0]     DIG_OFF  = DIG_LOW ? 4'hF : 4'h0;
  localparam logic [7:0]     SEG_OFF  = SEG_LOW ? 8'hFF : 8'h00;

  // Scan timebase and frame shadow state
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sValue;
  logic [3:0]    sDots;
  logic          sBlank;
  logic          primed;

  // Next-state values, also used to build the registered pins
  logic [CW-1:0] cntNext;
  logic [1:0]    idxNext;
  logic [15:0]   sValueNext;
  logic [3:0]    sDotsNext;
  logic          sBlankNext;
  logic          load;
  logic          wrap;

  // Pin values for the next cycle
  logic [3:0]    digNext;
  logic [7:0]    segNext;
  logic          lit;

  // Lit-window decision on the next counter value; with no blank interval the
  // digit stays lit for the whole slot
  if (BLANK == 0) begin : g_noBlank
    assign lit = 1'b1;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    assign lit = (cntNext >= BLANK_C);
  end

  // State register: counter, digit index, frame shadows and primed flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      sValue <= 16'h0000;
      sDots  <= 4'h0;
      sBlank <= 1'b0;
      primed <= 1'b0;
    end else begin
      cnt    <= cntNext;
      idx    <= idxNext;
      sValue <= sValueNext;
      sDots  <= sDotsNext;
      sBlank <= sBlankNext;
      primed <= 1'b1;
    end
  end

  // Next-state: advance the slot counter, step the digit at slot end, and
  // reload the shadows on the first edge after reset or when a new frame begins
  always_comb begin
    wrap       = (cnt == CNT_LAST);
    cntNext    = wrap ? '0 : cnt + CW'(1);
    idxNext    = wrap ? idx + 2'd1 : idx;
    load       = !primed || (wrap && (idx == 2'd3));
    sValueNext = load ? value        : sValue;
    sDotsNext  = load ? dots         : sDots;
    sBlankNext = load ? blankLeading : sBlank;
  end

  // Output decode: select the digit, hex-decode its nibble, suppress leading
  // zeros on digits 1..3, then apply pin polarity
  always_comb begin
    logic [3:0] nib;
    logic [6:0] hexSeg;
    logic [3:0] leadZero;
    logic       suppress;
    logic [3:0] digHigh;
    logic [7:0] segHigh;

    nib = sValueNext[{idxNext, 2'b00} +: 4];

    case (nib)
      4'h0:    hexSeg = 7'h3F;
      4'h1:    hexSeg = 7'h06;
      4'h2:    hexSeg = 7'h5B;
      4'h3:    hexSeg = 7'h4F;
      4'h4:    hexSeg = 7'h66;
      4'h5:    hexSeg = 7'h6D;
      4'h6:    hexSeg = 7'h7D;
      4'h7:    hexSeg = 7'h07;
      4'h8:    hexSeg = 7'h7F;
      4'h9:    hexSeg = 7'h6F;
      4'hA:    hexSeg = 7'h77;
      4'hB:    hexSeg = 7'h7C;
      4'hC:    hexSeg = 7'h39;
      4'hD:    hexSeg = 7'h5E;
      4'hE:    hexSeg = 7'h79;
      default: hexSeg = 7'h71;
    endcase

    leadZero[3] = (sValueNext[15:12] == 4'h0);
    leadZero[2] = leadZero[3] && (sValueNext[11:8] == 4'h0);
    leadZero[1] = leadZero[2] && (sValueNext[7:4] == 4'h0);
    leadZero[0] = 1'b0;
    suppress    = sBlankNext && leadZero[idxNext];

    digHigh = 4'h0;
    segHigh = 8'h00;
    if (lit) begin
      digHigh = 4'b0001 << idxNext;
      segHigh = {sDotsNext[idxNext], suppress ? 7'h00 : hexSeg};
    end

    digNext = DIG_LOW ? ~digHigh : digHigh;
    segNext = SEG_LOW ? ~segHigh : segHigh;
  end

  // Registered pins and frame pulse; reset forces the tube dark immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tubeDig    <= DIG_OFF;
      tubeSeg    <= SEG_OFF;
      frameStart <= 1'b0;
    end else begin
      tubeDig    <= digNext;
      tubeSeg    <= segNext;
      frameStart <= load;
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Testbench for tube_scan_driver: a PRESCALE=4/BLANK=1 instance checked with
// a slot scoreboard, plus a PRESCALE=2/BLANK=0 instance checked cycle by cycle.

module tb_tube_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        blankLeading;
  logic [3:0]  tubeDig;
  logic [7:0]  tubeSeg;
  logic        frameStart;

  logic        rst2;
  logic [3:0]  tubeDig2;
  logic [7:0]  tubeSeg2;
  logic        frameStart2;

  int checks = 0;
  int errors = 0;

  logic [11:0] sbQ[$];
  bit          sbStrict = 1'b0;

  logic [6:0] hexTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  tube_scan_driver #(.PRESCALE(4), .BLANK(1), .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dots(dots), .blankLeading(blankLeading),
    .tubeDig(tubeDig), .tubeSeg(tubeSeg), .frameStart(frameStart)
  );

  tube_scan_driver #(.PRESCALE(2), .BLANK(0), .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst(rst2), .value(16'h8421), .dots(4'h0), .blankLeading(1'b0),
    .tubeDig(tubeDig2), .tubeSeg(tubeSeg2), .frameStart(frameStart2)
  );

  always #5 clk = ~clk;

  // Count a comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected active-low {tubeDig, tubeSeg} for digit i of a frame
  function automatic logic [11:0] expSlot(input logic [15:0] v, input logic [3:0] d,
                                          input logic bl, input int i);
    logic [3:0] nib;
    logic [6:0] g;
    logic [3:0] dg;
    logic [7:0] sg;
    nib = v[i*4 +: 4];
    g   = hexTab[nib];
    if (bl && (i > 0) && ((v >> (4*i)) == 16'h0000)) g = 7'h00;
    dg = ~(4'b0001 << i);
    sg = ~{d[i], g};
    return {dg, sg};
  endfunction

  // Wait for the next frame pulse with a cycle budget
  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (frameStart) seen = 1'b1;
    end
    if (!seen) checkOutput("frameTimeout", frameStart, 1);
  endtask

  // Drive a frame's inputs, queue its four expected slots, wait for its load,
  // then move into digit 1 of that frame
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic bl);
    value        = v;
    dots         = d;
    blankLeading = bl;
    for (int i = 0; i < 4; i++) sbQ.push_back(expSlot(v, d, bl, i));
    waitFrame();
    repeat (6) @(negedge clk);
  endtask

  // Slot monitor: compares each new lit slot against the scoreboard, checks
  // lit-run length and the frame pulse period
  logic [3:0]  prevDig = 4'hF;
  int          runLen  = 0;
  int          fsCount = 0;
  int          cyc     = 0;
  always @(negedge clk) begin
    logic [11:0] exp;
    if (rst) begin
      prevDig = 4'hF;
      runLen  = 0;
      fsCount = 0;
      cyc     = 0;
    end else begin
      if (tubeDig != 4'hF) begin
        if (prevDig == 4'hF) begin
          if (sbQ.size() > 0) begin
            exp = sbQ.pop_front();
            checkOutput("slot", {tubeDig, tubeSeg}, exp);
          end else if (sbStrict) begin
            checkOutput("slotUnexpected", sbQ.size(), 1);
          end
          runLen = 1;
        end else begin
          runLen++;
        end
      end else if (prevDig != 4'hF) begin
        checkOutput("litLen", runLen, 3);
      end
      cyc++;
      if (frameStart) begin
        if (fsCount >= 2) checkOutput("framePeriod", cyc, 16);
        fsCount++;
        cyc = 0;
      end
      prevDig = tubeDig;
    end
  end

  // Main sequence
  initial begin
    int idx2;
    logic [11:0] e2;

    rst          = 1'b1;
    rst2         = 1'b1;
    value        = 16'h0000;
    dots         = 4'h0;
    blankLeading = 1'b0;
    #1;
    checkOutput("rstDig", tubeDig, 4'hF);
    checkOutput("rstSeg", tubeSeg, 8'hFF);
    checkOutput("rstFs", frameStart, 0);
    checkOutput("rstDig2", tubeDig2, 4'hF);

    // No-blank instance: lit every cycle, digit advances every two cycles
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx2 = (k / 2) % 4;
      e2   = expSlot(16'h8421, 4'h0, 1'b0, idx2);
      if (k == 1) checkOutput("b0FrameStart", frameStart2, 1);
      checkOutput("b0Dig", tubeDig2, e2[11:8]);
      checkOutput("b0Seg", tubeSeg2, e2[7:0]);
    end

    // Scanned instance: frames with snapshot changes mid-frame
    sbStrict     = 1'b1;
    value        = 16'h12AF;
    dots         = 4'h0;
    blankLeading = 1'b0;
    for (int i = 0; i < 4; i++) sbQ.push_back(expSlot(16'h12AF, 4'h0, 1'b0, i));
    @(negedge clk);
    rst = 1'b0;
    waitFrame();
    repeat (6) @(negedge clk);

    applyStimulus(16'h3456, 4'h0, 1'b0);
    applyStimulus(16'h0040, 4'h0, 1'b1);
    applyStimulus(16'h0000, 4'h0, 1'b1);
    applyStimulus(16'h0000, 4'b0101, 1'b1);
    applyStimulus(16'h0A00, 4'b1000, 1'b1);
    applyStimulus(16'hF00D, 4'b0110, 1'b1);
    applyStimulus(16'h7C9B, 4'hF, 1'b0);
    checkOutput("queueBeforeReset", sbQ.size(), 2);

    // Reset mid-scan: pins go dark immediately
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstDig", tubeDig, 4'hF);
    checkOutput("midRstSeg", tubeSeg, 8'hFF);
    checkOutput("midRstFs", frameStart, 0);
    sbQ.delete();
    value        = 16'hBEEF;
    dots         = 4'b1010;
    blankLeading = 1'b0;
    for (int i = 0; i < 4; i++) sbQ.push_back(expSlot(16'hBEEF, 4'b1010, 1'b0, i));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("fsAfterRelease", frameStart, 1);
    repeat (16) @(negedge clk);
    checkOutput("queueDrained", sbQ.size(), 0);
    sbStrict = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
